// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronises and glitch-filters A/B, decodes 4x quadrature
// into a one-cycle step strobe plus direction, and flags/counts illegal double-edge transitions.
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_in,
  input  logic                 b_in,
  input  logic                 clr_err,
  output logic                 step,
  output logic                 up,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int ICW = $clog2(SYNC_STAGES + 1);

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t                 state;
  logic [ICW-1:0]         init_cnt;
  logic [SYNC_STAGES-1:0] a_sync;
  logic [SYNC_STAGES-1:0] b_sync;
  logic [1:0]             sync_v;   // {a_s, b_s}
  logic [1:0]             filt;     // {filt_a, filt_b}
  logic [1:0]             prev;     // {prev_a, prev_b}
  logic [FCW-1:0]         fcnt [2];

  assign sync_v = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], a_in};
      b_sync <= {b_sync[SYNC_STAGES-2:0], b_in};
    end
  end

  // Per-channel filter: a new level is accepted only after FILTER_LEN consecutive
  // disagreeing samples; during INIT the filter is bypassed so it starts aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
      for (int ch = 0; ch < 2; ch++) fcnt[ch] <= '0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        if (state == INIT) begin
          filt[ch] <= sync_v[ch];
          fcnt[ch] <= '0;
        end else if (sync_v[ch] == filt[ch]) begin
          fcnt[ch] <= '0;
        end else if (fcnt[ch] == FCW'(FILTER_LEN - 1)) begin
          filt[ch] <= sync_v[ch];
          fcnt[ch] <= '0;
        end else begin
          fcnt[ch] <= fcnt[ch] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
      prev     <= '0;
      step     <= 1'b0;
      up       <= 1'b1;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      step <= 1'b0;
      err  <= 1'b0;
      case (state)
        INIT: begin
          if (init_cnt == ICW'(SYNC_STAGES)) begin
            // filt is loading sync_v on this same edge, so prev takes the same value
            prev  <= sync_v;
            state <= TRACK;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        TRACK: begin
          prev <= filt;
          case (filt ^ prev)
            2'b01, 2'b10: begin
              step <= 1'b1;
              up   <= prev[1] ^ filt[0];
            end
            2'b11: begin
              err <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
            default: ;
          endcase
        end
        default: state <= INIT;
      endcase
      if (clr_err) err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios plus random encoder traffic, checked
// every cycle against a sample-history model of the decoder.
module tb_quad_step_decoder;

  localparam int SS = 2;
  localparam int FL = 4;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_in = 1'b0;
  logic          b_in = 1'b0;
  logic          clr_err = 1'b0;
  logic          step;
  logic          up;
  logic          err;
  logic [CW-1:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int fail_prints = 0;
  bit done = 1'b0;

  logic [CW+2:0] exp_q [$];

  quad_step_decoder #(.SYNC_STAGES(SS), .FILTER_LEN(FL), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .clr_err(clr_err),
    .step(step), .up(up), .err(err), .err_cnt(err_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit raw_a [$];
  bit raw_b [$];
  bit win_a [$];
  bit win_b [$];
  bit mf_a, mf_b, mp_a, mp_b;
  bit m_up;
  int m_cnt;
  int n_edge;

  function automatic int gpos(bit a, bit b);
    case ({a, b})
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit all_differ(bit w [$], bit f);
    if (w.size() < FL) return 1'b0;
    foreach (w[i]) if (w[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    raw_a.delete(); raw_b.delete(); win_a.delete(); win_b.delete();
    for (int i = 0; i < SS; i++) begin
      raw_a.push_back(1'b0);
      raw_b.push_back(1'b0);
    end
    mf_a = 0; mf_b = 0; mp_a = 0; mp_b = 0;
    m_up = 1'b1; m_cnt = 0; n_edge = 0;
  endtask

  task automatic model_edge();
    bit sa, sb, es, ee;
    int d;
    es = 0; ee = 0;
    if (n_edge < 1000) n_edge++;
    // the synchronised level seen now is the raw sample taken SS edges ago
    sa = raw_a[raw_a.size() - SS];
    sb = raw_b[raw_b.size() - SS];
    raw_a.push_back(a_in);
    raw_b.push_back(b_in);
    if (raw_a.size() > 16) begin
      void'(raw_a.pop_front());
      void'(raw_b.pop_front());
    end
    if (n_edge <= SS + 1) begin
      mf_a = sa; mf_b = sb;
      if (n_edge == SS + 1) begin
        mp_a = sa; mp_b = sb;
      end
    end else begin
      d = (gpos(mf_a, mf_b) - gpos(mp_a, mp_b)) & 3;
      if (d == 1) begin es = 1; m_up = 1; end
      if (d == 3) begin es = 1; m_up = 0; end
      if (d == 2) begin ee = 1; if (m_cnt < CMAX) m_cnt++; end
      mp_a = mf_a; mp_b = mf_b;
      win_a.push_back(sa); win_b.push_back(sb);
      if (win_a.size() > FL) begin
        void'(win_a.pop_front());
        void'(win_b.pop_front());
      end
      if (all_differ(win_a, mf_a)) mf_a = sa;
      if (all_differ(win_b, mf_b)) mf_b = sb;
    end
    if (clr_err) m_cnt = 0;
    exp_q.push_back({es, m_up, ee, m_cnt[CW-1:0]});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        if (clk) exp_q.push_back({1'b0, 1'b1, 1'b0, {CW{1'b0}}});
        else exp_q.delete();
      end else begin
        model_edge();
      end
    end
  end

  // ---------------- scoreboard ----------------
  initial begin
    logic [CW+2:0] e;
    forever begin
      @(negedge clk);
      if (!done && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({step, up, err, err_cnt} !== e) begin
          errors++;
          if (fail_prints < 30) begin
            fail_prints++;
            $display("FAIL cycle_compare t=%0t {step,up,err,err_cnt} actual=%b_%b_%b_%0d expected=%b_%b_%b_%0d",
                     $time, step, up, err, err_cnt, e[CW+2], e[CW+1], e[CW], e[CW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_lit(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Drive A/B at a negedge, hold for `hold` posedges, report step/err counts and first pulse index.
  task automatic apply_ab(input logic [1:0] v, input int hold,
                          output int n_step, output int step_at, output int n_err, output int err_at);
    n_step = 0; step_at = 0; n_err = 0; err_at = 0;
    @(negedge clk);
    a_in = v[1];
    b_in = v[0];
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk);
      #1;
      if (step) begin n_step++; if (step_at == 0) step_at = i; end
      if (err)  begin n_err++;  if (err_at == 0)  err_at = i;  end
    end
  endtask

  task automatic reset_pulse(input int cycles);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_lit("async_reset_step", step, 0);
    check_lit("async_reset_up", up, 1);
    check_lit("async_reset_err", err, 0);
    check_lit("async_reset_cnt", err_cnt, 0);
    repeat (cycles) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ns, sat, ne, eat;
    logic [1:0] fwd [4];
    logic [1:0] rev [4];
    logic [1:0] v;
    fwd[0] = 2'b01; fwd[1] = 2'b11; fwd[2] = 2'b10; fwd[3] = 2'b00;
    rev[0] = 2'b10; rev[1] = 2'b11; rev[2] = 2'b01; rev[3] = 2'b00;

    repeat (3) @(negedge clk);
    #1;
    check_lit("reset_up", up, 1);
    check_lit("reset_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      apply_ab(fwd[i], 10, ns, sat, ne, eat);
      check_lit("fwd_steps", ns, 1);
      check_lit("fwd_latency", sat, 7);
      check_lit("fwd_up", up, 1);
    end
    check_lit("fwd_err_cnt", err_cnt, 0);

    for (int i = 0; i < 4; i++) begin
      apply_ab(rev[i], 10, ns, sat, ne, eat);
      check_lit("rev_steps", ns, 1);
      check_lit("rev_latency", sat, 7);
    end
    check_lit("rev_up_held", up, 0);

    apply_ab(2'b10, 3, ns, sat, ne, eat);
    apply_ab(2'b00, 12, ns, sat, ne, eat);
    check_lit("glitch_steps", ns, 0);
    apply_ab(2'b10, 4, ns, sat, ne, eat);
    check_lit("held4_early_steps", ns, 0);
    apply_ab(2'b00, 12, ns, sat, ne, eat);
    check_lit("held4_steps", ns, 2);
    check_lit("held4_first_at", sat, 3);

    apply_ab(2'b11, 10, ns, sat, ne, eat);
    check_lit("illegal_err_pulses", ne, 1);
    check_lit("illegal_err_at", eat, 7);
    check_lit("illegal_steps", ns, 0);
    check_lit("illegal_cnt", err_cnt, 1);
    for (int i = 0; i < 255; i++) begin
      v = (i % 2 == 0) ? 2'b00 : 2'b11;
      apply_ab(v, 7, ns, sat, ne, eat);
    end
    check_lit("sat_cnt", err_cnt, 255);

    @(negedge clk);
    a_in = 1'b1; b_in = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    check_lit("clr_same_edge_err", err, 1);
    check_lit("clr_same_edge_cnt", err_cnt, 0);
    @(negedge clk);
    clr_err = 1'b0;
    repeat (5) @(negedge clk);
    check_lit("clr_cnt_stays", err_cnt, 0);

    for (int i = 2; i < 4; i++) apply_ab(rev[i], 10, ns, sat, ne, eat);
    for (int i = 0; i < 2; i++) apply_ab(rev[i], 10, ns, sat, ne, eat);
    check_lit("pre_reset_up", up, 0);
    reset_pulse(1);
    apply_ab(2'b11, 20, ns, sat, ne, eat);
    check_lit("post_reset_steps", ns, 0);
    check_lit("post_reset_errs", ne, 0);
    apply_ab(2'b01, 10, ns, sat, ne, eat);
    check_lit("resume_step_at", sat, 7);
    check_lit("resume_up", up, 0);

    for (int i = 0; i < 400; i++) begin
      clr_err = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 79) == 0) reset_pulse($urandom_range(1, 3));
      v = 2'($urandom_range(0, 3));
      apply_ab(v, $urandom_range(1, 9), ns, sat, ne, eat);
    end
    clr_err = 1'b0;
    repeat (12) @(negedge clk);

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
